seq_detect_fsm: RTL

//  Parametrised Moore sequence-detector FSM; generalises the fixed 4-state serial-pattern FSMs.

---
 rtl/seq_detect_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//   Moore sequence detector for a fixed serial pattern of PAT_LEN bits.
//   The state is the number of pattern bits currently matched (0..PAT_LEN).
//   State PAT_LEN is MATCH. On a mismatch the FSM falls back to the longest
//   pattern prefix that is still a suffix of the received stream (KMP fallback).
//   The transition table is built from PATTERN at elaboration time.
//   A saturating counter records how many matches were seen.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PATTERN  pattern; bit PAT_LEN-1 is the first bit received
//   OVERLAP  1 = overlapping matches allowed, 0 = restart search after a match
//   CNT_W    width of the match counter
//
// Ports
//   clk     in   rising-edge clock
//   resetn  in   synchronous active-low reset (overrides en)
//   en      in   1 = sample 'in' this cycle, 0 = hold all state
//   in      in   serial data bit
//   out     out  1 iff state == MATCH (decoded from the state register only)
//   state   out  current state = number of pattern bits matched
//   count   out  saturating match count
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic                         in,
  output logic                         out,
  output logic [$clog2(PAT_LEN+1)-1:0] state,
  output logic [CNT_W-1:0]             count
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 2 ** SW;

  typedef enum logic [SW-1:0] {
    ST_IDLE  = SW'(0),
    ST_MATCH = SW'(PAT_LEN)
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // i-th pattern bit in order of reception
  function automatic logic pbit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Longest proper border of PATTERN (prefix that is also a suffix)
  function automatic int calc_border();
    int  res;
    bit  ok;
    res = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < PAT_LEN; j++) begin
        if (j < k) begin
          if (pbit(j) != pbit(PAT_LEN - k + j)) begin
            ok = 1'b0;
          end
        end
      end
      if (ok) begin
        res = k;
      end
    end
    return res;
  endfunction

  localparam int BORDER = calc_border();

  // Next state from state s on input b. The received tail is modelled as the
  // first 'eff' pattern bits followed by b; the result is the longest pattern
  // prefix that ends that string. A match naturally yields eff+1.
  function automatic int kmp_next(input int s, input logic b);
    int   eff;
    int   res;
    int   idx;
    bit   ok;
    logic c;
    if (s >= PAT_LEN) begin
      eff = OVERLAP ? BORDER : 0;
    end else begin
      eff = s;
    end
    res = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= eff + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_LEN; j++) begin
          if (j < k) begin
            idx = eff + 1 - k + j;
            if (idx == eff) begin
              c = b;
            end else begin
              c = pbit(idx);
            end
            if (c != pbit(j)) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          res = k;
        end
      end
    end
    return res;
  endfunction

  // Constant transition tables; unreachable encodings go to idle.
  logic [SW-1:0] w_nxt0 [0:NS-1];
  logic [SW-1:0] w_nxt1 [0:NS-1];

  for (genvar gs = 0; gs < NS; gs++) begin : g_tbl
    if (gs <= PAT_LEN) begin : g_live
      localparam int N0 = kmp_next(gs, 1'b0);
      localparam int N1 = kmp_next(gs, 1'b1);
      assign w_nxt0[gs] = SW'(N0);
      assign w_nxt1[gs] = SW'(N1);
    end else begin : g_dead
      assign w_nxt0[gs] = SW'(0);
      assign w_nxt1[gs] = SW'(0);
    end
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Next-state and next-count logic
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (en) begin
      if (in) begin
        w_state_nxt = state_t'(w_nxt1[r_state]);
      end else begin
        w_state_nxt = state_t'(w_nxt0[r_state]);
      end
      if ((w_state_nxt == ST_MATCH) && (r_count != CNT_MAX)) begin
        w_count_nxt = r_count + CNT_W'(1);
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign out   = (r_state == ST_MATCH);
  assign state = r_state;
  assign count = r_count;

endmodule
